// File: rtl/timer_pkg.sv
// Definitions shared by the timer register block and the bus master that polls it.
package timer_pkg;

  localparam logic [1:0] ADDR_COUNT  = 2'd0;
  localparam logic [1:0] ADDR_MODE   = 2'd1;
  localparam logic [1:0] ADDR_RELOAD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // Bit of the status register that carries the finish flag.
  localparam int unsigned STATUS_FLAG_BIT = 0;

  typedef enum logic [1:0] {
    MODE_STOP = 2'd0,
    MODE_UP   = 2'd1,
    MODE_DOWN = 2'd2,
    MODE_AUTO = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CHK  = 3'd1,
    ST_SNAP = 3'd2,
    ST_CLR  = 3'd3,
    ST_CMD  = 3'd4
  } poll_state_t;

  typedef enum logic {
    SRC_POLL = 1'b0,
    SRC_CMD  = 1'b1
  } src_t;

  function automatic logic busy(input poll_state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/timer_irq_poller.sv
// Timer bus master: forwards host commands, polls the finish flag, snapshots the
// counter on each finish and raises a sticky, maskable interrupt.
module timer_irq_poller
  import timer_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned POLL_INTERVAL = 16,
  parameter int unsigned IRQ_CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     timer_run,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_we,
  input  logic [1:0]               cmd_addr,
  input  logic [COUNTER_WIDTH-1:0] cmd_data,
  output logic                     rsp_valid,
  output logic [COUNTER_WIDTH-1:0] rsp_data,
  input  logic                     irq_en,
  input  logic                     irq_ack,
  output logic                     irq,
  output logic [IRQ_CNT_W-1:0]     irq_count,
  output logic [COUNTER_WIDTH-1:0] snapshot,
  output logic                     t_en,
  output logic                     t_we,
  output logic                     t_re,
  output logic [1:0]               t_addr,
  output logic [COUNTER_WIDTH-1:0] t_load,
  input  logic [COUNTER_WIDTH-1:0] t_rdata
);

  localparam logic [15:0]          POLL_LAST = 16'(POLL_INTERVAL - 1);
  localparam logic [IRQ_CNT_W-1:0] CNT_ONE   = IRQ_CNT_W'(1);

  poll_state_t              state_q, state_d;
  src_t                     src_q, src_d;
  logic [15:0]              poll_cnt_q, poll_cnt_d;
  logic                     cmd_we_q, cmd_we_d;
  logic [1:0]               cmd_addr_q, cmd_addr_d;
  logic [COUNTER_WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic [COUNTER_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     irq_pending_q, irq_pending_d;
  logic [IRQ_CNT_W-1:0]     irq_count_q, irq_count_d;
  logic [COUNTER_WIDTH-1:0] snapshot_q, snapshot_d;
  logic                     event_set;

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    poll_cnt_d    = poll_cnt_q;
    cmd_we_d      = cmd_we_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_data_d    = cmd_data_q;
    rsp_data_d    = rsp_data_q;
    rsp_valid_d   = 1'b0;
    irq_pending_d = irq_pending_q;
    irq_count_d   = irq_count_q;
    snapshot_d    = snapshot_q;
    event_set     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The counter parks at its last value so a poll deferred by a host
        // command is taken on the first free IDLE cycle.
        if (timer_run && (poll_cnt_q != POLL_LAST)) begin
          poll_cnt_d = poll_cnt_q + 16'd1;
        end
        if (cmd_valid) begin
          cmd_we_d   = cmd_we;
          cmd_addr_d = cmd_addr;
          cmd_data_d = cmd_data;
          if (cmd_we) begin
            state_d    = ST_CHK;
            src_d      = SRC_CMD;
            poll_cnt_d = '0;
          end else begin
            state_d = ST_CMD;
          end
        end else if (timer_run && (poll_cnt_q == POLL_LAST)) begin
          state_d    = ST_CHK;
          src_d      = SRC_POLL;
          poll_cnt_d = '0;
        end
      end
      ST_CHK: begin
        if (t_rdata[STATUS_FLAG_BIT]) begin
          state_d = ST_SNAP;
        end else if (src_q == SRC_CMD) begin
          state_d = ST_CMD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SNAP: begin
        snapshot_d = t_rdata;
        event_set  = 1'b1;
        // A pending host write clears the flag itself, so no CLR is needed.
        state_d    = (src_q == SRC_CMD) ? ST_CMD : ST_CLR;
      end
      ST_CLR: begin
        state_d = ST_IDLE;
      end
      ST_CMD: begin
        if (!cmd_we_q) begin
          rsp_data_d  = t_rdata;
          rsp_valid_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (event_set) begin
      irq_pending_d = 1'b1;
      if (irq_count_q != '1) begin
        irq_count_d = irq_count_q + CNT_ONE;
      end
    end else if (irq_ack) begin
      irq_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      src_q         <= SRC_POLL;
      poll_cnt_q    <= '0;
      cmd_we_q      <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_data_q    <= '0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      irq_pending_q <= 1'b0;
      irq_count_q   <= '0;
      snapshot_q    <= '0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      poll_cnt_q    <= poll_cnt_d;
      cmd_we_q      <= cmd_we_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_data_q    <= cmd_data_d;
      rsp_data_q    <= rsp_data_d;
      rsp_valid_q   <= rsp_valid_d;
      irq_pending_q <= irq_pending_d;
      irq_count_q   <= irq_count_d;
      snapshot_q    <= snapshot_d;
    end
  end

  always_comb begin
    t_we   = 1'b0;
    t_re   = 1'b0;
    t_addr = ADDR_COUNT;
    t_load = '0;
    unique case (state_q)
      ST_CHK: begin
        t_re   = 1'b1;
        t_addr = ADDR_STATUS;
      end
      ST_SNAP: begin
        t_re   = 1'b1;
        t_addr = ADDR_COUNT;
      end
      ST_CLR: begin
        t_we   = 1'b1;
        t_addr = ADDR_STATUS;
      end
      ST_CMD: begin
        t_addr = cmd_addr_q;
        if (cmd_we_q) begin
          t_we   = 1'b1;
          t_load = cmd_data_q;
        end else begin
          t_re = 1'b1;
        end
      end
      default: begin
        t_we = 1'b0;
      end
    endcase
  end

  assign t_en      = ~rst & (timer_run | busy(state_q));
  assign cmd_ready = ~rst & (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign irq       = irq_pending_q & irq_en;
  assign irq_count = irq_count_q;
  assign snapshot  = snapshot_q;

endmodule

// File: tb/tb_timer_irq_poller.sv
// Directed bench for timer_irq_poller: a vector table with a driven timer read bus,
// then hand-written sequences against a small timer register model.
module tb_timer_irq_poller;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        timer_run, cmd_valid, cmd_ready, cmd_we;
  logic [1:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        irq_en, irq_ack, irq;
  logic [7:0]  irq_count;
  logic [31:0] snapshot;
  logic        t_en, t_we, t_re;
  logic [1:0]  t_addr;
  logic [31:0] t_load, t_rdata;

  logic        use_model;
  logic [31:0] vec_rdata, model_rdata;
  logic [31:0] m_count, m_reload;
  mode_t       m_mode;
  logic        m_flag;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  timer_irq_poller #(.COUNTER_WIDTH(32), .POLL_INTERVAL(16), .IRQ_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .timer_run(timer_run),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .irq_en(irq_en), .irq_ack(irq_ack), .irq(irq),
    .irq_count(irq_count), .snapshot(snapshot),
    .t_en(t_en), .t_we(t_we), .t_re(t_re), .t_addr(t_addr),
    .t_load(t_load), .t_rdata(t_rdata)
  );

  // Timer register model: down-counts in MODE_DOWN, sets the flag on reaching 0,
  // any write clears the flag and stalls the count for that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count  <= '0;
      m_reload <= '0;
      m_mode   <= MODE_STOP;
      m_flag   <= 1'b0;
    end else if (t_en) begin
      if (t_we) begin
        m_flag <= 1'b0;
        case (t_addr)
          2'd0:    m_count  <= t_load;
          2'd1:    m_mode   <= mode_t'(t_load[1:0]);
          2'd2:    m_reload <= t_load;
          default: ;
        endcase
      end else if (m_mode == MODE_DOWN && m_count != 0) begin
        m_count <= m_count - 1;
        if (m_count == 1) m_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    case (t_addr)
      2'd0:    model_rdata = m_count;
      2'd1:    model_rdata = {30'b0, m_mode};
      2'd2:    model_rdata = m_reload;
      default: model_rdata = {31'b0, m_flag};
    endcase
  end

  assign t_rdata = use_model ? model_rdata : vec_rdata;

  typedef struct {
    logic run; logic cv; logic we; logic [1:0] addr; logic [31:0] data;
    logic [31:0] rdata; logic ack; logic ien;
    logic e_ready; logic e_ten; logic e_twe; logic e_tre; logic [1:0] e_taddr;
    logic [31:0] e_tload; logic e_rv; logic [31:0] e_rd; logic e_irq;
    logic [7:0] e_cnt; logic [31:0] e_snap;
  } vec_t;

  vec_t vecs[28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] a, input logic [31:0] d);
    int unsigned n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_data = d;
    while (n < 50) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (!ok) chk("cmd_accept_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    int first_chk, second_chk, third_chk, nchk, nwe;
    logic found;

    rst = 1'b1; timer_run = 0; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_data = 0;
    irq_en = 1; irq_ack = 0; use_model = 0; vec_rdata = 0;

    //       run cv we addr data     rdata    ack ien | rdy ten twe tre ta tload   rv rd       irq cnt snap
    vecs[0]  = '{0, 0, 0, 0, 0,       0,       0, 1,  1, 0, 0, 0, 0, 0,       0, 0,       0, 0, 0};
    vecs[1]  = '{0, 1, 1, 2, 'h1234,  0,       0, 1,  1, 0, 0, 0, 0, 0,       0, 0,       0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0,       0,       0, 1,  0, 1, 0, 1, 3, 0,       0, 0,       0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0,       0,       0, 1,  0, 1, 1, 0, 2, 'h1234,  0, 0,       0, 0, 0};
    vecs[4]  = '{0, 1, 0, 2, 0,       0,       0, 1,  1, 0, 0, 0, 0, 0,       0, 0,       0, 0, 0};
    vecs[5]  = '{0, 0, 0, 0, 0,       'h1234,  0, 1,  0, 1, 0, 1, 2, 0,       0, 0,       0, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 0,       0,       0, 1,  1, 0, 0, 0, 0, 0,       1, 'h1234,  0, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 0,       0,       0, 1,  1, 0, 0, 0, 0, 0,       0, 'h1234,  0, 0, 0};
    vecs[8]  = '{0, 1, 1, 1, 2,       0,       0, 1,  1, 0, 0, 0, 0, 0,       0, 'h1234,  0, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 0,       1,       0, 1,  0, 1, 0, 1, 3, 0,       0, 'h1234,  0, 0, 0};
    vecs[10] = '{0, 0, 0, 0, 0,       'h55,    0, 1,  0, 1, 0, 1, 0, 0,       0, 'h1234,  0, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 0,       0,       0, 1,  0, 1, 1, 0, 1, 2,       0, 'h1234,  1, 1, 'h55};
    vecs[12] = '{0, 0, 0, 0, 0,       0,       1, 1,  1, 0, 0, 0, 0, 0,       0, 'h1234,  1, 1, 'h55};
    vecs[13] = '{0, 0, 0, 0, 0,       0,       0, 1,  1, 0, 0, 0, 0, 0,       0, 'h1234,  0, 1, 'h55};
    vecs[14] = '{0, 1, 1, 0, 7,       0,       0, 0,  1, 0, 0, 0, 0, 0,       0, 'h1234,  0, 1, 'h55};
    vecs[15] = '{0, 0, 0, 0, 0,       1,       0, 0,  0, 1, 0, 1, 3, 0,       0, 'h1234,  0, 1, 'h55};
    vecs[16] = '{0, 0, 0, 0, 0,       'h99,    0, 0,  0, 1, 0, 1, 0, 0,       0, 'h1234,  0, 1, 'h55};
    vecs[17] = '{0, 0, 0, 0, 0,       0,       0, 0,  0, 1, 1, 0, 0, 7,       0, 'h1234,  0, 2, 'h99};
    vecs[18] = '{0, 0, 0, 0, 0,       0,       0, 1,  1, 0, 0, 0, 0, 0,       0, 'h1234,  1, 2, 'h99};
    vecs[19] = '{0, 1, 1, 3, 0,       0,       0, 1,  1, 0, 0, 0, 0, 0,       0, 'h1234,  1, 2, 'h99};
    vecs[20] = '{0, 0, 0, 0, 0,       1,       0, 1,  0, 1, 0, 1, 3, 0,       0, 'h1234,  1, 2, 'h99};
    vecs[21] = '{0, 0, 0, 0, 0,       'hAB,    1, 1,  0, 1, 0, 1, 0, 0,       0, 'h1234,  1, 2, 'h99};
    vecs[22] = '{0, 0, 0, 0, 0,       0,       0, 1,  0, 1, 1, 0, 3, 0,       0, 'h1234,  1, 3, 'hAB};
    vecs[23] = '{0, 0, 0, 0, 0,       0,       1, 1,  1, 0, 0, 0, 0, 0,       0, 'h1234,  1, 3, 'hAB};
    vecs[24] = '{0, 0, 0, 0, 0,       0,       0, 1,  1, 0, 0, 0, 0, 0,       0, 'h1234,  0, 3, 'hAB};
    vecs[25] = '{0, 0, 0, 0, 0,       0,       1, 1,  1, 0, 0, 0, 0, 0,       0, 'h1234,  0, 3, 'hAB};
    vecs[26] = '{0, 0, 0, 0, 0,       0,       0, 1,  1, 0, 0, 0, 0, 0,       0, 'h1234,  0, 3, 'hAB};
    vecs[27] = '{1, 0, 0, 0, 0,       0,       0, 1,  1, 1, 0, 0, 0, 0,       0, 'h1234,  0, 3, 'hAB};

    repeat (2) @(negedge clk);
    chk("rst_t_en", 32'(t_en), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_t_we_re", {30'b0, t_we, t_re}, 0);
    chk("rst_t_addr_load", t_load | 32'(t_addr), 0);
    chk("rst_rsp", rsp_data | 32'(rsp_valid), 0);
    chk("rst_irq_state", 32'({irq, irq_count}), 0);
    chk("rst_snapshot", snapshot, 0);
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      @(posedge clk); #1;
      timer_run = vecs[i].run; cmd_valid = vecs[i].cv; cmd_we = vecs[i].we;
      cmd_addr = vecs[i].addr; cmd_data = vecs[i].data; vec_rdata = vecs[i].rdata;
      irq_ack = vecs[i].ack; irq_en = vecs[i].ien;
      @(negedge clk);
      chk($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_t_en", i), 32'(t_en), 32'(vecs[i].e_ten));
      chk($sformatf("v%0d_t_we", i), 32'(t_we), 32'(vecs[i].e_twe));
      chk($sformatf("v%0d_t_re", i), 32'(t_re), 32'(vecs[i].e_tre));
      chk($sformatf("v%0d_t_addr", i), 32'(t_addr), 32'(vecs[i].e_taddr));
      chk($sformatf("v%0d_t_load", i), t_load, vecs[i].e_tload);
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
      chk($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].e_rd);
      chk($sformatf("v%0d_irq", i), 32'(irq), 32'(vecs[i].e_irq));
      chk($sformatf("v%0d_irq_count", i), 32'(irq_count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_snapshot", i), snapshot, vecs[i].e_snap);
    end

    // Poll cadence against the timer model, no host traffic.
    @(negedge clk);
    rst = 1'b1; timer_run = 0; cmd_valid = 0; irq_ack = 0; irq_en = 1; use_model = 1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    timer_run = 1'b1;
    first_chk = -1; second_chk = -1; third_chk = -1; nchk = 0; nwe = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (t_we) nwe++;
      if (t_re && t_addr == 2'd3) begin
        if (nchk == 0) first_chk = c;
        else if (nchk == 1) second_chk = c;
        else if (nchk == 2) third_chk = c;
        nchk++;
      end
    end
    chk("cadence_first", 32'(first_chk), 32'd16);
    chk("cadence_gap1", 32'(second_chk - first_chk), 32'd17);
    chk("cadence_gap2", 32'(third_chk - second_chk), 32'd17);
    chk("cadence_no_writes", 32'(nwe), 32'd0);

    // Down-count finish detected by a poll.
    @(posedge clk); #1;
    issue(1'b1, 2'd0, 32'd5);
    issue(1'b1, 2'd1, 32'd2);
    found = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (t_re && t_addr == 2'd3 && t_rdata[0]) begin
        found = 1'b1;
        break;
      end
    end
    chk("finish_flag_polled", 32'(found), 1);
    @(negedge clk);
    chk("finish_snap_cycle", {t_re, t_we, t_addr}, {1'b1, 1'b0, 2'd0});
    @(negedge clk);
    chk("finish_clr_cycle", {t_re, t_we, t_addr}, {1'b0, 1'b1, 2'd3});
    chk("finish_clr_load", t_load, 0);
    chk("finish_snapshot", snapshot, 0);
    chk("finish_irq_count", 32'(irq_count), 1);
    chk("finish_irq", 32'(irq), 1);
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (t_re && t_addr == 2'd3) begin
        found = 1'b1;
        break;
      end
    end
    chk("finish_next_poll_seen", 32'(found), 1);
    chk("finish_next_poll_flag", 32'(t_rdata[0]), 0);
    @(negedge clk);
    chk("finish_next_poll_idle", 32'(cmd_ready), 1);

    // Host write racing a set flag: CHK, SNAP, CMD and no CLR.
    @(posedge clk); #1;
    irq_ack = 1'b1;
    @(posedge clk); #1;
    irq_ack = 1'b0;
    @(negedge clk);
    chk("race_acked_irq", 32'(irq), 0);
    @(posedge clk); #1;
    issue(1'b1, 2'd0, 32'd3);
    repeat (6) @(posedge clk);
    #1;
    issue(1'b1, 2'd1, 32'd2);
    @(negedge clk);
    chk("race_chk", {t_re, t_addr, t_rdata[0]}, {1'b1, 2'd3, 1'b1});
    @(negedge clk);
    chk("race_snap", {t_re, t_we, t_addr}, {1'b1, 1'b0, 2'd0});
    @(negedge clk);
    chk("race_cmd", {t_we, t_addr}, {1'b1, 2'd1});
    chk("race_cmd_load", t_load, 2);
    chk("race_irq", 32'(irq), 1);
    chk("race_irq_count", 32'(irq_count), 2);
    @(negedge clk);
    chk("race_no_clr", {cmd_ready, t_we}, {1'b1, 1'b0});

    // Host read of the reload register.
    @(posedge clk); #1;
    issue(1'b1, 2'd2, 32'h1234);
    issue(1'b0, 2'd2, 32'd0);
    @(negedge clk);
    chk("read_gap_ready", 32'(cmd_ready), 0);
    chk("read_gap_rsp_valid", 32'(rsp_valid), 0);
    chk("read_cmd_bus", {t_re, t_addr}, {1'b1, 2'd2});
    @(negedge clk);
    chk("read_rsp_valid", 32'(rsp_valid), 1);
    chk("read_rsp_data", rsp_data, 32'h1234);

    // Reset asserted while a poll-triggered SNAP is on the bus.
    @(posedge clk); #1;
    issue(1'b1, 2'd0, 32'd2);
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (t_re && t_addr == 2'd0) begin
        found = 1'b1;
        break;
      end
    end
    chk("rstsnap_seen", 32'(found), 1);
    #1 rst = 1'b1;
    #1;
    chk("rstsnap_t_en", 32'(t_en), 0);
    chk("rstsnap_bus", {t_we, t_re, t_addr}, 0);
    chk("rstsnap_t_load", t_load, 0);
    chk("rstsnap_rsp", rsp_data | 32'(rsp_valid), 0);
    chk("rstsnap_irq", 32'({irq, irq_count}), 0);
    chk("rstsnap_snapshot", snapshot, 0);
    chk("rstsnap_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstsnap_idle_after", {cmd_ready, t_re, t_we, t_en}, {1'b1, 1'b0, 1'b0, 1'b1});
    chk("rstsnap_count_after", 32'(irq_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
